// File: rtl/branch_recovery_seq.sv
// Mispredict recovery sequencer: flush, walk the ROB youngest-first back to the branch, then redirect fetch.
// Optional BRANCH_RECOVERY_STATS_EN adds saturating mispredict and busy-cycle counters.
module branch_recovery_seq #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mispredict_i,
  input  logic [31:0]      target_pc_i,
  input  logic [ROB_W-1:0] recover_tag_i,
  input  logic [ROB_W-1:0] rob_head_i,
  input  logic [ROB_W-1:0] rob_tail_i,
  output logic             busy_o,
  output logic             flush_o,
  output logic             walk_valid_o,
  output logic [ROB_W-1:0] walk_idx_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [ROB_W-1:0] tail_set_o
`ifdef BRANCH_RECOVERY_STATS_EN
  ,
  output logic [31:0]      mp_count_o,
  output logic [31:0]      recov_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, WALK, REDIRECT} state_t;

  localparam logic [ROB_W-1:0] ONE      = ROB_W'(1);
  localparam logic [ROB_W-1:0] IDX_MASK = ROB_W'(ROB_DEPTH - 1);

  state_t           state_q, state_d;
  logic [ROB_W-1:0] tag_q, tag_d;
  logic [31:0]      pc_q, pc_d;
  logic [ROB_W-1:0] ptr_q, ptr_d;
  logic [ROB_W-1:0] new_age, cur_age, tag_plus1;

  // Ages are distances from the ROB head, so the wrap point never confuses the compare
  assign new_age   = (recover_tag_i - rob_head_i) & IDX_MASK;
  assign cur_age   = (tag_q - rob_head_i) & IDX_MASK;
  assign tag_plus1 = (tag_q + ONE) & IDX_MASK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      pc_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (mispredict_i) begin
          tag_d   = recover_tag_i;
          pc_d    = target_pc_i;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (mispredict_i && (new_age < cur_age)) begin
          tag_d = recover_tag_i;
          pc_d  = target_pc_i;
        end
        ptr_d   = (rob_tail_i - ONE) & IDX_MASK;
        state_d = (ptr_d == tag_d) ? REDIRECT : WALK;
      end
      WALK: begin
        // The branch entry itself commits normally, so the walk stops one short of it
        ptr_d = (ptr_q - ONE) & IDX_MASK;
        if (ptr_q == tag_plus1) state_d = REDIRECT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign busy_o           = (state_q != IDLE);
  assign flush_o          = (state_q == FLUSH);
  assign walk_valid_o     = (state_q == WALK);
  assign walk_idx_o       = (state_q == WALK) ? ptr_q : '0;
  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pc_o    = (state_q == REDIRECT) ? pc_q : '0;
  assign tail_set_o       = (state_q == REDIRECT) ? tag_plus1 : '0;

`ifdef BRANCH_RECOVERY_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mp_count_o     <= '0;
      recov_cycles_o <= '0;
    end else begin
      if ((state_q == IDLE) && (state_d == FLUSH) && (mp_count_o != 32'hFFFF_FFFF))
        mp_count_o <= mp_count_o + 32'd1;
      if (busy_o && (recov_cycles_o != 32'hFFFF_FFFF))
        recov_cycles_o <= recov_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_recovery_seq.sv
// Randomized bench for branch_recovery_seq against a schedule model derived from ROB occupancy arithmetic.
// Define BRANCH_RECOVERY_STATS_EN to also check the statistics counters.
module tb_branch_recovery_seq;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_W     = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mispredict = 1'b0;
  logic [31:0]      target_pc = '0;
  logic [ROB_W-1:0] recover_tag = '0;
  logic [ROB_W-1:0] rob_head = '0;
  logic [ROB_W-1:0] rob_tail = '0;
  logic             busy, flush, walk_valid, redirect_valid;
  logic [ROB_W-1:0] walk_idx, tail_set;
  logic [31:0]      redirect_pc;
`ifdef BRANCH_RECOVERY_STATS_EN
  logic [31:0]      mp_count, recov_cycles;
`endif

  int total = 0;
  int bad   = 0;

  branch_recovery_seq #(.ROB_DEPTH(ROB_DEPTH), .ROB_W(ROB_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mispredict_i     (mispredict),
    .target_pc_i      (target_pc),
    .recover_tag_i    (recover_tag),
    .rob_head_i       (rob_head),
    .rob_tail_i       (rob_tail),
    .busy_o           (busy),
    .flush_o          (flush),
    .walk_valid_o     (walk_valid),
    .walk_idx_o       (walk_idx),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .tail_set_o       (tail_set)
`ifdef BRANCH_RECOVERY_STATS_EN
    ,
    .mp_count_o       (mp_count),
    .recov_cycles_o   (recov_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic mp, input logic [ROB_W-1:0] tag, input logic [31:0] pc);
    mispredict  = mp;
    recover_tag = tag;
    target_pc   = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distance of a tag from the head: the model's notion of age
  function automatic int ageOf(input int tag, input int head);
    return (tag - head + ROB_DEPTH) % ROB_DEPTH;
  endfunction

  task automatic checkIdle(input string where);
    checkOutput({where, ".busy"}, 32'(busy), 32'd0);
    checkOutput({where, ".flush"}, 32'(flush), 32'd0);
    checkOutput({where, ".walk_valid"}, 32'(walk_valid), 32'd0);
    checkOutput({where, ".walk_idx"}, 32'(walk_idx), 32'd0);
    checkOutput({where, ".redirect_valid"}, 32'(redirect_valid), 32'd0);
    checkOutput({where, ".redirect_pc"}, redirect_pc, 32'd0);
    checkOutput({where, ".tail_set"}, 32'(tail_set), 32'd0);
  endtask

  // One full recovery; the caller is in an IDLE cycle. sec adds a second mispredict in the FLUSH cycle,
  // junk drives ignored mispredicts during WALK and REDIRECT.
  task automatic runRecovery(input int head, input int tail, input int tag1, input logic [31:0] pc1,
                             input bit sec, input int tag2, input logic [31:0] pc2, input bit junk);
    int          effTag;
    logic [31:0] effPc;
    int          n;
    rob_head = ROB_W'(head);
    rob_tail = ROB_W'(tail);
    applyStimulus(1'b1, ROB_W'(tag1), pc1);
    tick();
    checkOutput("flush.flush", 32'(flush), 32'd1);
    checkOutput("flush.busy", 32'(busy), 32'd1);
    checkOutput("flush.walk_valid", 32'(walk_valid), 32'd0);
    checkOutput("flush.redirect_valid", 32'(redirect_valid), 32'd0);
    applyStimulus(sec, ROB_W'(tag2), pc2);
    effTag = tag1;
    effPc  = pc1;
    if (sec && ageOf(tag2, head) < ageOf(tag1, head)) begin
      effTag = tag2;
      effPc  = pc2;
    end
    n = (tail - effTag - 1 + 2 * ROB_DEPTH) % ROB_DEPTH;
    tick();
    for (int k = 0; k < n; k++) begin
      checkOutput("walk.walk_valid", 32'(walk_valid), 32'd1);
      checkOutput("walk.walk_idx", 32'(walk_idx), 32'((tail - 1 - k + 2 * ROB_DEPTH) % ROB_DEPTH));
      checkOutput("walk.busy", 32'(busy), 32'd1);
      checkOutput("walk.flush", 32'(flush), 32'd0);
      checkOutput("walk.redirect_valid", 32'(redirect_valid), 32'd0);
      applyStimulus(junk ? 1'($urandom) : 1'b0, ROB_W'($urandom), $urandom);
      tick();
    end
    checkOutput("redir.redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("redir.redirect_pc", redirect_pc, effPc);
    checkOutput("redir.tail_set", 32'(tail_set), 32'((effTag + 1) % ROB_DEPTH));
    checkOutput("redir.busy", 32'(busy), 32'd1);
    checkOutput("redir.walk_valid", 32'(walk_valid), 32'd0);
    applyStimulus(junk ? 1'($urandom) : 1'b0, ROB_W'($urandom), $urandom);
    tick();
    applyStimulus(1'b0, '0, '0);
    checkIdle("after");
  endtask

  initial begin
    int head, tail, cnt, tag1, tag2;
    applyStimulus(1'b0, '0, '0);
    rst_n = 1'b0;
    tick();
    tick();
    checkIdle("reset");
    rst_n = 1'b1;

    runRecovery(0, 5, 2, 32'h100, 1'b0, 0, 0, 1'b0);
`ifdef BRANCH_RECOVERY_STATS_EN
    checkOutput("stats.mp_count", mp_count, 32'd1);
    checkOutput("stats.recov_cycles", recov_cycles, 32'd4);
`endif
    runRecovery(0, 3, 2, 32'h140, 1'b0, 0, 0, 1'b0);
    runRecovery(14, 1, 14, 32'h180, 1'b0, 0, 0, 1'b0);
    runRecovery(0, 8, 6, 32'h1C0, 1'b1, 3, 32'h200, 1'b0);
    runRecovery(0, 12, 6, 32'h240, 1'b1, 9, 32'h280, 1'b1);
    runRecovery(5, 5, 5, 32'h2C0, 1'b0, 0, 0, 1'b0);

    // Reset in the middle of a walk, then a normal recovery
    rob_head = 4'd0;
    rob_tail = 4'd10;
    applyStimulus(1'b1, 4'd2, 32'h300);
    tick();
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    checkOutput("prereset.walk_valid", 32'(walk_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    checkIdle("midreset");
    rst_n = 1'b1;
    tick();
    checkIdle("postreset");
    runRecovery(0, 10, 2, 32'h340, 1'b0, 0, 0, 1'b0);

    for (int s = 0; s < 40; s++) begin
      head = int'($urandom_range(0, ROB_DEPTH - 1));
      tail = ($urandom_range(0, 3) == 0) ? head : int'($urandom_range(0, ROB_DEPTH - 1));
      cnt  = (tail - head + ROB_DEPTH) % ROB_DEPTH;
      if (cnt == 0) cnt = ROB_DEPTH;
      tag1 = (head + int'($urandom_range(0, cnt - 1))) % ROB_DEPTH;
      tag2 = (head + int'($urandom_range(0, cnt - 1))) % ROB_DEPTH;
      runRecovery(head, tail, tag1, $urandom, 1'($urandom), tag2, $urandom, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
